adc_channel_sequencer: RTL and testbench
========================================

ADC_CHANNEL_SEQUENCER -- requirements
Module: adc_channel_sequencer

Interface
REQ-001 Parameter BITS, default 8, SAR result width.
REQ-002 Parameter NUM_CH, default 4, analog input channels (2..16).
REQ-003 Parameter SETTLE_CYCLES, default 4, sampling/settle cycles after mux switch (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 32, max cycles waiting for conversion.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 scan_start  input  1  one-cycle pulse requesting a scan; ignored while busy.
REQ-008 cont_mode  input  1  high: restart scan automatically at end of scan.
REQ-009 ch_mask  input  NUM_CH  channel enable mask, latched at scan start.
REQ-010 ch_sel  output  clog2(NUM_CH)  analog mux select.
REQ-011 sar_rst_n  output  1  synchronous reset to SAR controller.
REQ-012 adc_start  output  1  conversion start to SAR controller.
REQ-013 sar_out_valid  input  1  SAR conversion complete.
REQ-014 sar_adc_val  input  BITS  SAR result.
REQ-015 result_data / result_ch  output  BITS / clog2(NUM_CH)  captured result and its channel.
REQ-016 result_valid / result_ready  output / input  1 / 1  result handshake; transfer when both high.
REQ-017 busy / scan_done / timeout_err  output  1 each  scan active / one-cycle end-of-scan pulse / sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, SELECT, SETTLE, START, CONVERT, OUTPUT.
REQ-019 IDLE: sar_rst_n=0, busy=0; on scan_start latch ch_mask, clear timeout_err, set channel pointer to 0, go SELECT.
REQ-020 SELECT: search pointer upward for lowest enabled channel; found -> drive ch_sel, go SETTLE; none left -> pulse scan_done one cycle, go SELECT with relatched mask and pointer 0 if cont_mode=1, else IDLE.
REQ-021 Empty mask SHALL produce scan_done one cycle after SELECT entry with no adc_start.
REQ-022 SETTLE: sar_rst_n=0, ch_sel stable, stay exactly SETTLE_CYCLES cycles, then START.
REQ-023 START: sar_rst_n=1, adc_start=1 for exactly one cycle, then CONVERT.
REQ-024 CONVERT: sar_rst_n=1, adc_start=0; sar_out_valid sampled high -> capture sar_adc_val into result_data, ch_sel into result_ch, set result_valid, go OUTPUT.
REQ-025 CONVERT timeout: TIMEOUT_CYCLES cycles without sar_out_valid -> set timeout_err, produce no result, advance pointer, go SELECT.
REQ-026 OUTPUT: sar_rst_n=0; hold result_valid, result_data, result_ch stable until result_ready=1; on transfer clear result_valid, advance pointer, go SELECT.
REQ-027 result_ready=0 SHALL stall the scan indefinitely without data loss or extra conversions.
REQ-028 Pointer advancing past NUM_CH-1 SHALL terminate the scan (no wrap within a scan).
REQ-029 ch_mask changes during a scan SHALL have no effect until next scan start.
REQ-030 scan_start while busy SHALL be ignored; cont_mode deassertion takes effect at next end-of-scan.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 ch_sel SHALL change only in SELECT.

Reset
REQ-033 rst_n=0 at any time, including mid-conversion or mid-stall, SHALL within one edge force IDLE, ch_sel=0, sar_rst_n=0, adc_start=0, result_valid=0, result_data=0, result_ch=0, busy=0, scan_done=0, timeout_err=0, pointer=0.

Verification
REQ-034 mask=4'b1111, result_ready=1, SAR model returning 8'hA5 per channel -> four results, result_ch 0,1,2,3 in order, then one scan_done pulse, IDLE.
REQ-035 mask=4'b1010 -> results only for channels 1 and 3; SETTLE lasts exactly 4 cycles sar_rst_n=0 before each single-cycle adc_start.
REQ-036 mask=0 -> scan_done one cycle after SELECT, adc_start never asserted.
REQ-037 result_ready held 0 for 20 cycles on first result -> result_valid/data stable, no adc_start, sar_rst_n=0; release -> scan continues at next channel.
REQ-038 SAR model never asserts out_valid on channel 2 -> timeout_err=1 after 32 CONVERT cycles, channel 2 skipped, channel 3 converted, timeout_err cleared on next scan_start.
REQ-039 cont_mode=1, rst_n pulsed low during CONVERT of second scan -> all outputs at reset values next cycle, no scan restart until scan_start.

Source files
------------

// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer: scans enabled analog channels through a SAR ADC and hands each result out over a valid/ready port.
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   i_scan_start      : one-cycle scan request, ignored while busy
//   i_cont_mode       : restart the scan automatically at end of scan
//   i_ch_mask         : channel enable mask, latched at scan start
//   o_ch_sel          : analog mux select
//   o_sar_rst_n       : synchronous reset to the SAR controller
//   o_adc_start       : one-cycle conversion start to the SAR controller
//   i_sar_out_valid   : SAR conversion complete
//   i_sar_adc_val     : SAR conversion result
//   o_result_data/ch  : captured result and the channel it came from
//   o_result_valid    : result handshake valid, i_result_ready: handshake ready
//   o_busy            : scan in progress
//   o_scan_done       : one-cycle end-of-scan pulse
//   o_timeout_err     : sticky conversion timeout flag, cleared at scan start
module adc_channel_sequencer #(
    parameter int BITS           = 8,
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_scan_start,
    input  logic                      i_cont_mode,
    input  logic [NUM_CH-1:0]         i_ch_mask,
    output logic [$clog2(NUM_CH)-1:0] o_ch_sel,
    output logic                      o_sar_rst_n,
    output logic                      o_adc_start,
    input  logic                      i_sar_out_valid,
    input  logic [BITS-1:0]           i_sar_adc_val,
    output logic [BITS-1:0]           o_result_data,
    output logic [$clog2(NUM_CH)-1:0] o_result_ch,
    output logic                      o_result_valid,
    input  logic                      i_result_ready,
    output logic                      o_busy,
    output logic                      o_scan_done,
    output logic                      o_timeout_err
);
    localparam int CW      = $clog2(NUM_CH);
    // One extra pointer bit so the pointer can step past the last channel and end the scan.
    localparam int PW      = CW + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int NW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_START, S_CONVERT, S_OUTPUT} state_t;

    state_t            r_state, w_next;
    logic [NUM_CH-1:0] r_mask;
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_ch_sel;
    logic [NW-1:0]     r_cnt;
    logic [BITS-1:0]   r_result_data;
    logic [CW-1:0]     r_result_ch;
    logic              r_result_valid;
    logic              r_scan_done;
    logic              r_timeout_err;
    logic              w_found;
    logic [CW-1:0]     w_idx;
    logic              w_settle_done;
    logic              w_timeout;

    // Lowest enabled channel at or above the pointer; scanning downward lets the lowest hit win.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && PW'(i) >= r_ptr) begin
                w_found = 1'b1;
                w_idx   = CW'(i);
            end
        end
    end

    assign w_settle_done = r_cnt == NW'(SETTLE_CYCLES - 1);
    assign w_timeout     = r_cnt == NW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = i_scan_start ? S_SELECT : S_IDLE;
            S_SELECT:  w_next = w_found ? S_SETTLE : (i_cont_mode ? S_SELECT : S_IDLE);
            S_SETTLE:  w_next = w_settle_done ? S_START : S_SETTLE;
            S_START:   w_next = S_CONVERT;
            S_CONVERT: w_next = i_sar_out_valid ? S_OUTPUT : (w_timeout ? S_SELECT : S_CONVERT);
            S_OUTPUT:  w_next = i_result_ready ? S_SELECT : S_OUTPUT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask         <= '0;
            r_ptr          <= '0;
            r_ch_sel       <= '0;
            r_cnt          <= '0;
            r_result_data  <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_scan_start) begin
                        r_mask        <= i_ch_mask;
                        r_ptr         <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        r_ch_sel <= w_idx;
                        r_ptr    <= PW'(w_idx);
                        r_cnt    <= '0;
                    end else begin
                        // End of scan; in continuous mode the next scan starts from a fresh mask.
                        r_scan_done <= 1'b1;
                        r_ptr       <= '0;
                        if (i_cont_mode) r_mask <= i_ch_mask;
                    end
                end
                S_SETTLE: r_cnt <= r_cnt + NW'(1);
                S_START:  r_cnt <= '0;
                S_CONVERT: begin
                    if (i_sar_out_valid) begin
                        r_result_data  <= i_sar_adc_val;
                        r_result_ch    <= r_ch_sel;
                        r_result_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_ptr         <= r_ptr + PW'(1);
                    end else begin
                        r_cnt <= r_cnt + NW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (i_result_ready) begin
                        r_result_valid <= 1'b0;
                        r_ptr          <= r_ptr + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The SAR is held in reset everywhere except around its own conversion.
    assign o_sar_rst_n    = (r_state == S_START) || (r_state == S_CONVERT);
    assign o_adc_start    = r_state == S_START;
    assign o_busy         = r_state != S_IDLE;
    assign o_ch_sel       = r_ch_sel;
    assign o_result_data  = r_result_data;
    assign o_result_ch    = r_result_ch;
    assign o_result_valid = r_result_valid;
    assign o_scan_done    = r_scan_done;
    assign o_timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb_adc_channel_sequencer: randomized scoreboard bench for adc_channel_sequencer with a SAR responder model.
module tb_adc_channel_sequencer;
    localparam int BITS   = 8;
    localparam int NUM_CH = 4;
    localparam int SETTLE = 4;
    localparam int TMO    = 32;
    localparam int CW     = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scan_start = 1'b0;
    logic              cont_mode = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [CW-1:0]     ch_sel;
    logic              sar_rst_n, adc_start;
    logic              sar_valid = 1'b0;
    logic [BITS-1:0]   sar_data = '0;
    logic [BITS-1:0]   result_data;
    logic [CW-1:0]     result_ch;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic              busy, scan_done, timeout_err;

    adc_channel_sequencer #(.BITS(BITS), .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .i_scan_start(scan_start), .i_cont_mode(cont_mode), .i_ch_mask(ch_mask),
        .o_ch_sel(ch_sel), .o_sar_rst_n(sar_rst_n), .o_adc_start(adc_start),
        .i_sar_out_valid(sar_valid), .i_sar_adc_val(sar_data),
        .o_result_data(result_data), .o_result_ch(result_ch), .o_result_valid(result_valid),
        .i_result_ready(result_ready), .o_busy(busy), .o_scan_done(scan_done), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CW+BITS-1:0] exp_q[$];
    logic [BITS-1:0]    sar_val[NUM_CH];
    bit                 dead[NUM_CH];
    int done_cnt = 0, start_cnt = 0, stall_gen = 0, stall_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SAR responder: answers each adc_start after 1..4 cycles unless the channel is dead or held in reset.
    initial begin
        int cd;
        logic [CW-1:0] sch;
        cd = 0;
        sch = '0;
        forever begin
            @(negedge clk);
            sar_valid = 1'b0;
            sar_data  = BITS'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !dead[sch] && sar_rst_n) begin
                    sar_valid = 1'b1;
                    sar_data  = sar_val[sch];
                end
            end
            if (adc_start) begin
                sch = ch_sel;
                cd  = $urandom_range(1, 4);
            end
        end
    end

    // Monitor: drives ready, pops the scoreboard on each transfer and checks timing rules.
    initial begin
        logic prev_valid, prev_ready, prev_start, prev_done, prev_tmo, chg, rdy;
        logic [CW+BITS-1:0] prev_res;
        logic [CW-1:0] prev_ch;
        int cyc, last_change, last_start, seen_gen, stall_left;
        prev_valid = 0; prev_ready = 0; prev_start = 0; prev_done = 0; prev_tmo = 0; chg = 0;
        prev_res = '0; prev_ch = '0; cyc = 0; last_change = 0; last_start = 0; seen_gen = 0; stall_left = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) exp_q.delete();
            if (result_valid === 1'b1) begin
                if (prev_valid && !prev_ready) chk("hold_stable", {result_ch, result_data}, prev_res);
                chk("stall_quiet", {adc_start, sar_rst_n}, 0);
                if (seen_gen != stall_gen) begin
                    seen_gen   = stall_gen;
                    stall_left = stall_len;
                end
            end
            if (result_valid === 1'b1 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = $urandom_range(0, 3) != 0;
            end
            result_ready = rdy;
            if (result_valid === 1'b1 && rdy) begin
                if (exp_q.size() == 0) chk("unexpected_result", {result_ch, result_data}, 0 - 1);
                else chk("result", {result_ch, result_data}, exp_q.pop_front());
            end
            prev_valid = result_valid === 1'b1;
            prev_ready = rdy;
            prev_res   = {result_ch, result_data};
            if (busy !== 1'b1) chg = 0;
            else if (ch_sel != prev_ch) begin
                chg = 1;
                last_change = cyc;
            end
            prev_ch = ch_sel;
            if (adc_start === 1'b1) begin
                start_cnt++;
                chk("start_single", prev_start, 0);
                chk("start_sar_rst", sar_rst_n, 1);
                if (chg) begin
                    chk("settle_len", cyc - last_change, SETTLE);
                    chg = 0;
                end
                last_start = cyc;
            end
            prev_start = adc_start === 1'b1;
            if (timeout_err === 1'b1 && !prev_tmo) chk("timeout_latency", cyc - last_start, TMO + 1);
            prev_tmo = timeout_err === 1'b1;
            if (scan_done === 1'b1) begin
                done_cnt++;
                chk("done_single", prev_done, 0);
            end
            prev_done = scan_done === 1'b1;
        end
    end

    // Reference model: a scan yields, in channel order, one result per enabled live channel.
    task automatic push_scan(input logic [NUM_CH-1:0] mask);
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c] && !dead[c]) exp_q.push_back({CW'(c), sar_val[c]});
    endtask

    task automatic run_scan(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] dmask,
                            input int stall, input bit fixed);
        int d0, s0, n;
        for (int c = 0; c < NUM_CH; c++) begin
            sar_val[c] = fixed ? 8'hA5 : BITS'($urandom);
            dead[c]    = dmask[c];
        end
        push_scan(mask);
        stall_len = stall;
        stall_gen++;
        d0 = done_cnt;
        s0 = start_cnt;
        @(negedge clk);
        ch_mask = mask;
        scan_start = 1'b1;
        @(negedge clk);
        ch_mask = ~mask;
        chk("busy_after_start", busy, 1);
        chk("timeout_cleared", timeout_err, 0);
        @(negedge clk);
        scan_start = 1'b0;
        if (mask == 0) begin
            chk("empty_done_pulse", scan_done, 1);
            chk("empty_idle", busy, 0);
        end
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("scan_finished", 64'(n < 3000), 1);
        chk("done_count", done_cnt - d0, 1);
        chk("start_count", start_cnt - s0, $countones(mask));
        chk("results_drained", exp_q.size(), 0);
        chk("timeout_flag", timeout_err, |(mask & dmask));
    endtask

    initial begin
        int n, d0, s0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ch_sel, sar_rst_n, adc_start, result_valid, result_data, result_ch,
                              busy, scan_done, timeout_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_scan(4'b1111, 4'b0000, 0, 1);
        run_scan(4'b1010, 4'b0000, 0, 0);
        run_scan(4'b0000, 4'b0000, 0, 0);
        run_scan(4'b1111, 4'b0000, 20, 0);
        run_scan(4'b1111, 4'b0100, 0, 0);
        run_scan(4'b1001, 4'b0000, 0, 0);
        for (int k = 0; k < 20; k++)
            run_scan(NUM_CH'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? NUM_CH'(1 << $urandom_range(0, 3)) : '0,
                     $urandom_range(0, 1) ? $urandom_range(1, 8) : 0, 0);

        // Continuous mode, reset during the second scan's conversion.
        for (int c = 0; c < NUM_CH; c++) begin
            sar_val[c] = BITS'($urandom);
            dead[c]    = 1'b0;
        end
        push_scan(4'b0110);
        push_scan(4'b0110);
        stall_len = 0;
        stall_gen++;
        d0 = done_cnt;
        cont_mode = 1'b1;
        @(negedge clk);
        ch_mask = 4'b0110;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("cont_first_done", 64'(n < 500), 1);
        n = 0;
        while (adc_start !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("cont_restarted", 64'(n < 500), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midscan_reset", {ch_sel, sar_rst_n, adc_start, result_valid, result_data, result_ch,
                              busy, scan_done, timeout_err}, 0);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        #1;
        chk("no_restart_busy", busy, 0);
        chk("no_restart_start", start_cnt - s0, 0);
        cont_mode = 1'b0;
        run_scan(4'b0101, 4'b0000, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
